// File: rtl/pusch_pkg.sv
// Shared constants, FSM encoding and latched-config record for the PUSCH RE mapper.
package pusch_pkg;

   localparam int NUM_SC  = 1200;
   localparam int NUM_SYM = 14;
   localparam int RB_SC   = 12;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SYM_SETUP = 3'd1;
   localparam logic [2:0] ST_MAP_DMRS  = 3'd2;
   localparam logic [2:0] ST_MAP_DATA  = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef struct packed {
      logic [10:0] sc_start;
      logic [11:0] last;
      logic [3:0]  sym_start;
      logic [3:0]  sym_end;
      logic        comb;
   } cfg_t;

endpackage

// File: rtl/re_cfg_check.sv
// Allocation sanity check and last-subcarrier computation for a mapping request.
module re_cfg_check #(
   parameter int NUM_SC  = pusch_pkg::NUM_SC,
   parameter int NUM_SYM = pusch_pkg::NUM_SYM
) (
   input  logic [10:0] cfg_sc_start,
   input  logic [6:0]  cfg_nrb,
   input  logic [3:0]  cfg_sym_start,
   input  logic [3:0]  cfg_sym_end,
   output logic [11:0] last,
   output logic        err
);

   logic [11:0] span;

   // 12 bits covers the worst case 2047 + 127*12 without wrap.
   assign span = 12'(cfg_nrb) * 12'(pusch_pkg::RB_SC);
   assign last = 12'(cfg_sc_start) + span - 12'd1;

   assign err = (cfg_nrb == 7'd0)
             || (int'(last) >= NUM_SC)
             || (cfg_sym_start > cfg_sym_end)
             || (int'(cfg_sym_end) >= NUM_SYM);

endmodule

// File: rtl/re_mapper_gen.sv
// Writes DMRS (comb-interleaved with zeros) and data samples onto the slot resource grid.
module re_mapper_gen
   import pusch_pkg::*;
#(
   parameter int IQ_W    = 18,
   parameter int DMRS_W  = 9,
   parameter int NUM_SC  = pusch_pkg::NUM_SC,
   parameter int NUM_SYM = pusch_pkg::NUM_SYM
) (
   input  logic                     CLK_RE,
   input  logic                     RST_RE,
   input  logic                     start,
   input  logic [10:0]              cfg_sc_start,
   input  logic [6:0]               cfg_nrb,
   input  logic [3:0]               cfg_sym_start,
   input  logic [3:0]               cfg_sym_end,
   input  logic [NUM_SYM-1:0]       cfg_dmrs_map,
   input  logic                     cfg_comb,
   input  logic                     dmrs_valid,
   output logic                     dmrs_ready,
   input  logic signed [DMRS_W-1:0] dmrs_i,
   input  logic signed [DMRS_W-1:0] dmrs_q,
   input  logic                     data_valid,
   output logic                     data_ready,
   input  logic signed [IQ_W-1:0]   data_i,
   input  logic signed [IQ_W-1:0]   data_q,
   output logic                     re_wr_en,
   output logic [3:0]               re_sym,
   output logic [10:0]              re_sc,
   output logic signed [IQ_W-1:0]   re_i,
   output logic signed [IQ_W-1:0]   re_q,
   output logic                     busy,
   output logic                     sym_done,
   output logic                     map_done,
   output logic                     cfg_err
);

   logic [2:0]             state_q, state_d;
   cfg_t                   cfg_q, cfg_d;
   logic [NUM_SYM-1:0]     map_q, map_d;
   logic [3:0]             sym_q, sym_d;
   logic [10:0]            sc_q, sc_d;
   logic                   re_wr_en_q, re_wr_en_d;
   logic [3:0]             re_sym_q, re_sym_d;
   logic [10:0]            re_sc_q, re_sc_d;
   logic signed [IQ_W-1:0] re_i_q, re_i_d, re_q_q, re_q_d;
   logic                   sym_done_q, sym_done_d;
   logic                   map_done_q, map_done_d;
   logic                   cfg_err_q, cfg_err_d;

   logic [11:0]            chk_last;
   logic                   chk_err;
   logic                   on_comb, accept;
   logic signed [IQ_W-1:0] dmrs_i_ext, dmrs_q_ext;

   re_cfg_check #(.NUM_SC(NUM_SC), .NUM_SYM(NUM_SYM)) u_cfg_check (
      .cfg_sc_start  (cfg_sc_start),
      .cfg_nrb       (cfg_nrb),
      .cfg_sym_start (cfg_sym_start),
      .cfg_sym_end   (cfg_sym_end),
      .last          (chk_last),
      .err           (chk_err)
   );

   assign dmrs_i_ext = IQ_W'(dmrs_i);
   assign dmrs_q_ext = IQ_W'(dmrs_q);

   // Parity of the offset from the allocation start selects DMRS vs. zero REs.
   assign on_comb    = ((sc_q[0] ^ cfg_q.sc_start[0]) == cfg_q.comb);
   assign dmrs_ready = (state_q == ST_MAP_DMRS) && on_comb;
   assign data_ready = (state_q == ST_MAP_DATA);
   assign accept     = (data_ready && data_valid)
                    || ((state_q == ST_MAP_DMRS) && (!on_comb || dmrs_valid));

   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      map_d      = map_q;
      sym_d      = sym_q;
      sc_d       = sc_q;
      re_wr_en_d = 1'b0;
      re_sym_d   = re_sym_q;
      re_sc_d    = re_sc_q;
      re_i_d     = re_i_q;
      re_q_d     = re_q_q;
      sym_done_d = 1'b0;
      map_done_d = 1'b0;
      cfg_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (chk_err) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_d.sc_start  = cfg_sc_start;
                  cfg_d.last      = chk_last;
                  cfg_d.sym_start = cfg_sym_start;
                  cfg_d.sym_end   = cfg_sym_end;
                  cfg_d.comb      = cfg_comb;
                  map_d           = cfg_dmrs_map;
                  sym_d           = cfg_sym_start;
                  state_d         = ST_SYM_SETUP;
               end
            end
         end
         ST_SYM_SETUP: begin
            sc_d    = cfg_q.sc_start;
            state_d = map_q[sym_q] ? ST_MAP_DMRS : ST_MAP_DATA;
         end
         ST_MAP_DMRS, ST_MAP_DATA: begin
            if (accept) begin
               re_wr_en_d = 1'b1;
               re_sym_d   = sym_q;
               re_sc_d    = sc_q;
               if (data_ready) begin
                  re_i_d = data_i;
                  re_q_d = data_q;
               end else begin
                  re_i_d = on_comb ? dmrs_i_ext : '0;
                  re_q_d = on_comb ? dmrs_q_ext : '0;
               end
               if ({1'b0, sc_q} == cfg_q.last) begin
                  sym_done_d = 1'b1;
                  if (sym_q == cfg_q.sym_end) begin
                     map_done_d = 1'b1;
                     state_d    = ST_DONE;
                  end else begin
                     sym_d   = sym_q + 4'd1;
                     state_d = ST_SYM_SETUP;
                  end
               end else begin
                  sc_d = sc_q + 11'd1;
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_RE or negedge RST_RE) begin
      if (!RST_RE) begin
         state_q    <= ST_IDLE;
         cfg_q      <= '0;
         map_q      <= '0;
         sym_q      <= '0;
         sc_q       <= '0;
         re_wr_en_q <= 1'b0;
         re_sym_q   <= '0;
         re_sc_q    <= '0;
         re_i_q     <= '0;
         re_q_q     <= '0;
         sym_done_q <= 1'b0;
         map_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         map_q      <= map_d;
         sym_q      <= sym_d;
         sc_q       <= sc_d;
         re_wr_en_q <= re_wr_en_d;
         re_sym_q   <= re_sym_d;
         re_sc_q    <= re_sc_d;
         re_i_q     <= re_i_d;
         re_q_q     <= re_q_d;
         sym_done_q <= sym_done_d;
         map_done_q <= map_done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign re_wr_en = re_wr_en_q;
   assign re_sym   = re_sym_q;
   assign re_sc    = re_sc_q;
   assign re_i     = re_i_q;
   assign re_q     = re_q_q;
   assign sym_done = sym_done_q;
   assign map_done = map_done_q;
   assign cfg_err  = cfg_err_q;

endmodule

// File: doc/re_mapper_gen.md
RE_MAPPER_GEN -- requirements
Module: re_mapper_gen

Interface
REQ-001 SHALL have parameter IQ_W, default 18, meaning output and data-sample I/Q width.
REQ-002 SHALL have parameter DMRS_W, default 9, meaning DMRS I/Q width (DMRS_W <= IQ_W).
REQ-003 SHALL have parameter NUM_SC, default 1200, meaning subcarriers per symbol in the grid.
REQ-004 SHALL have parameter NUM_SYM, default 14, meaning symbols per slot.
REQ-005 SHALL use one clock and an asynchronous active-low reset: CLK_RE in 1 clock; RST_RE in 1 async active-low reset.
REQ-006 SHALL have ports: start in 1 (config-load pulse); cfg_sc_start in 11 (first subcarrier); cfg_nrb in 7 (allocated RBs).
REQ-007 SHALL have ports: cfg_sym_start in 4; cfg_sym_end in 4 (inclusive); cfg_dmrs_map in NUM_SYM (bit s=1 marks symbol s as DMRS); cfg_comb in 1 (DMRS comb offset).
REQ-008 SHALL have ports: dmrs_valid in 1; dmrs_ready out 1; dmrs_i, dmrs_q in DMRS_W signed.
REQ-009 SHALL have ports: data_valid in 1; data_ready out 1; data_i, data_q in IQ_W signed (transform-precoder output).
REQ-010 SHALL have ports: re_wr_en out 1; re_sym out 4; re_sc out 11; re_i, re_q out IQ_W signed.
REQ-011 SHALL have ports: busy out 1; sym_done out 1; map_done out 1; cfg_err out 1.

Function
REQ-012 SHALL latch all cfg_* on start while IDLE; start while busy SHALL be ignored.
REQ-013 SHALL define last = cfg_sc_start + 12*cfg_nrb - 1, computed at 12-bit width.
REQ-014 SHALL, at start, flag cfg_err for one cycle and stay IDLE if: cfg_nrb==0, last >= NUM_SC, cfg_sym_start > cfg_sym_end, or cfg_sym_end >= NUM_SYM.
REQ-015 SHALL implement states IDLE -> SYM_SETUP -> (MAP_DMRS | MAP_DATA) -> SYM_SETUP or DONE -> IDLE.
REQ-016 SYM_SETUP SHALL load sc counter = cfg_sc_start and select MAP_DMRS when cfg_dmrs_map[sym]=1, else MAP_DATA.
REQ-017 In MAP_DMRS, a subcarrier with ((sc - cfg_sc_start) mod 2) == cfg_comb SHALL assert dmrs_ready, advance only on dmrs_valid&&dmrs_ready, and write sign-extended dmrs_i/q.
REQ-018 In MAP_DMRS, each other subcarrier SHALL be written with zero in one cycle without consuming DMRS input; dmrs_ready SHALL be low on those cycles.
REQ-019 In MAP_DATA, every subcarrier SHALL assert data_ready and advance only on data_valid&&data_ready.
REQ-020 data_ready SHALL be 0 outside MAP_DATA; dmrs_ready SHALL be 0 outside MAP_DMRS.
REQ-021 Output SHALL be registered: re_wr_en/re_sym/re_sc/re_i/re_q SHALL appear exactly 1 cycle after the accepting cycle; there SHALL be no output backpressure.
REQ-022 sym_done SHALL pulse 1 cycle, coincident with the write of subcarrier last of each symbol.
REQ-023 map_done SHALL pulse 1 cycle, coincident with the final write of symbol cfg_sym_end.
REQ-024 In DONE the FSM SHALL return to IDLE on the next cycle; busy SHALL be high from the cycle after an accepted start until DONE inclusive.
REQ-025 Input stalls (valid low) SHALL hold the state and sc counter with re_wr_en=0; no RE SHALL be skipped or duplicated.
REQ-026 Writes SHALL cover exactly subcarriers cfg_sc_start..last in ascending order per symbol; unallocated subcarriers SHALL NOT be written.

Reset
REQ-027 On RST_RE low: state IDLE; all outputs 0; latched config 0; counters 0.
REQ-028 Reset asserted mid-mapping SHALL abort immediately with no further writes and no sym_done/map_done pulse.

Structure
REQ-029 State encoding, NUM_SC, NUM_SYM, RB_SC=12 SHALL live in shared package pusch_pkg.
REQ-030 The config check and last-index computation SHALL be one sub-module re_cfg_check; the rest is flat.

Verification
REQ-031 cfg_sc_start=0, nrb=1, sym 0..1, dmrs_map=0x0001, comb=0, continuous valid -> sym0 sc0,2..10 DMRS, odd zeros; sym1 12 data writes; two sym_done pulses; map_done at sc 11 of sym1.
REQ-032 cfg_sc_start=5, nrb=2, comb=1, dmrs_map=0x0004, sym 2..3 -> DMRS at sc 6,8..28; zeros at 5,7..27; 12 DMRS samples consumed.
REQ-033 nrb=100, sc_start=1 -> cfg_err pulse, busy stays 0, no writes; same with sym_start=5, sym_end=4.
REQ-034 Random data_valid/dmrs_valid gaps over 4 symbols -> write sequence identical to gap-free run, one write per handshake.
REQ-035 start pulsed again mid-symbol -> ignored, config unchanged; RST_RE low mid-symbol -> outputs 0 next edge, restart with new start succeeds.
